// File: rtl/ahb_input_stage_dma_phy.sv
// ahb_input_stage_dma_phy: per-master AHB input stage; forwards or holds the address phase and returns the slave response.
module ahb_input_stage_dma_phy #(
  parameter int ADDR_WIDTH   = 32,
  parameter int MASTER_WIDTH = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSELS,
  input  logic [ADDR_WIDTH-1:0]   HADDRS,
  input  logic [1:0]              HTRANSS,
  input  logic                    HWRITES,
  input  logic [2:0]              HSIZES,
  input  logic [2:0]              HBURSTS,
  input  logic [3:0]              HPROTS,
  input  logic [MASTER_WIDTH-1:0] HMASTERS,
  input  logic                    HMASTLOCKS,
  input  logic                    HREADYS,
  input  logic                    active_ip,
  input  logic                    readyout_ip,
  input  logic                    resp_ip,
  output logic                    sel_ip,
  output logic [ADDR_WIDTH-1:0]   addr_ip,
  output logic [1:0]              trans_ip,
  output logic                    write_ip,
  output logic [2:0]              size_ip,
  output logic [2:0]              burst_ip,
  output logic [3:0]              prot_ip,
  output logic [MASTER_WIDTH-1:0] master_ip,
  output logic                    mastlock_ip,
  output logic                    held_tran_ip,
  output logic                    HREADYOUTS,
  output logic                    HRESPS
);
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] INCR   = 3'b001;
  logic                    pend_tran, data_phase, burst_remap;
  logic                    cap_sel, cap_write, cap_lock;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [1:0]              cap_trans;
  logic [2:0]              cap_size, cap_burst;
  logic [3:0]              cap_prot;
  logic [MASTER_WIDTH-1:0] cap_master;
  logic                    new_tran, held_seq, held_remap, live_remap;
  assign new_tran   = HSELS & HTRANSS[1] & HREADYS;
  // A held SEQ loses its burst context, so it restarts as NONSEQ and any non-single burst continues as INCR.
  assign held_seq   = pend_tran & (cap_trans == SEQ);
  assign held_remap = held_seq & (cap_burst != 3'd0);
  assign live_remap = ~pend_tran & burst_remap & (HTRANSS == SEQ);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      pend_tran   <= 1'b0;
      data_phase  <= 1'b0;
      burst_remap <= 1'b0;
      cap_sel     <= 1'b0;
      cap_addr    <= '0;
      cap_trans   <= '0;
      cap_write   <= 1'b0;
      cap_size    <= '0;
      cap_burst   <= '0;
      cap_prot    <= '0;
      cap_master  <= '0;
      cap_lock    <= 1'b0;
    end else begin
      if (HREADYS) begin
        cap_sel    <= HSELS;
        cap_addr   <= HADDRS;
        cap_trans  <= HTRANSS;
        cap_write  <= HWRITES;
        cap_size   <= HSIZES;
        cap_burst  <= HBURSTS;
        cap_prot   <= HPROTS;
        cap_master <= HMASTERS;
        cap_lock   <= HMASTLOCKS;
      end
      if (active_ip && readyout_ip) pend_tran <= 1'b0;
      else if (new_tran) pend_tran <= 1'b1;
      if (readyout_ip) data_phase <= active_ip & held_tran_ip & sel_ip;
      if (held_remap) burst_remap <= 1'b1;
      else if (!pend_tran && HREADYS && !HTRANSS[0]) burst_remap <= 1'b0;
    end
  assign sel_ip       = pend_tran ? cap_sel : HSELS;
  assign addr_ip      = pend_tran ? cap_addr : HADDRS;
  assign trans_ip     = held_seq ? NONSEQ : pend_tran ? cap_trans : HTRANSS;
  assign write_ip     = pend_tran ? cap_write : HWRITES;
  assign size_ip      = pend_tran ? cap_size : HSIZES;
  assign burst_ip     = (held_remap || live_remap) ? INCR : pend_tran ? cap_burst : HBURSTS;
  assign prot_ip      = pend_tran ? cap_prot : HPROTS;
  assign master_ip    = pend_tran ? cap_master : HMASTERS;
  assign mastlock_ip  = pend_tran ? cap_lock : HMASTLOCKS;
  assign held_tran_ip = pend_tran | (HTRANSS[1] & HREADYS);
  assign HREADYOUTS   = pend_tran ? 1'b0 : data_phase ? readyout_ip : 1'b1;
  assign HRESPS       = data_phase & resp_ip;
endmodule

// File: tb/tb_ahb_input_stage_dma_phy.sv
// tb_ahb_input_stage_dma_phy: directed and random stimulus against a transaction-level model, checked through a scoreboard queue.
module tb_ahb_input_stage_dma_phy;
  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        lock;
  } xfer_t;
  typedef struct packed {
    logic  ready;
    logic  resp;
    logic  held;
    xfer_t x;
  } exp_t;
  logic        HCLK = 1'b1;
  logic        HRESETn = 1'b0;
  xfer_t       cur = '0;
  logic        hready = 1'b1;
  logic        active_ip = 1'b0, readyout_ip = 1'b1, resp_ip = 1'b0;
  logic        sel_ip, write_ip, mastlock_ip, held_tran_ip, HREADYOUTS, HRESPS;
  logic [31:0] addr_ip;
  logic [1:0]  trans_ip;
  logic [2:0]  size_ip, burst_ip;
  logic [3:0]  prot_ip, master_ip;
  int          n_cmp = 0, n_err = 0;
  exp_t        q[$];
  logic        m_hv = 1'b0, m_dp = 1'b0, m_remap = 1'b0;
  xfer_t       m_h = '0;
  always #5 HCLK = ~HCLK;
  ahb_input_stage_dma_phy dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(cur.sel), .HADDRS(cur.addr), .HTRANSS(cur.trans),
    .HWRITES(cur.write), .HSIZES(cur.size), .HBURSTS(cur.burst), .HPROTS(cur.prot),
    .HMASTERS(cur.master), .HMASTLOCKS(cur.lock), .HREADYS(hready), .active_ip(active_ip),
    .readyout_ip(readyout_ip), .resp_ip(resp_ip), .sel_ip(sel_ip), .addr_ip(addr_ip),
    .trans_ip(trans_ip), .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip),
    .prot_ip(prot_ip), .master_ip(master_ip), .mastlock_ip(mastlock_ip),
    .held_tran_ip(held_tran_ip), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  initial forever begin
    exp_t e;
    @(negedge HCLK);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("hreadyout", {63'd0, HREADYOUTS}, {63'd0, e.ready});
      chk("hresp", {63'd0, HRESPS}, {63'd0, e.resp});
      chk("held_tran", {63'd0, held_tran_ip}, {63'd0, e.held});
      chk("trans", {62'd0, trans_ip}, {62'd0, e.x.trans});
      chk("burst", {61'd0, burst_ip}, {61'd0, e.x.burst});
      chk("addr", {32'd0, addr_ip}, {32'd0, e.x.addr});
      chk("ctrl", {49'd0, sel_ip, write_ip, size_ip, prot_ip, master_ip, mastlock_ip},
          {49'd0, e.x.sel, e.x.write, e.x.size, e.x.prot, e.x.master, e.x.lock});
    end
  end
  // One bus cycle: the master sees the model's ready (acting as the HREADY mux), expectations are queued, then the model advances.
  task automatic step();
    xfer_t p;
    exp_t  e;
    logic  held;
    hready = m_hv ? 1'b0 : m_dp ? readyout_ip : 1'b1;
    p = m_hv ? m_h : cur;
    if (m_hv && m_h.trans == 2'b11) begin
      p.trans = 2'b10;
      if (m_h.burst != 3'b000) p.burst = 3'b001;
    end else if (!m_hv && m_remap && cur.trans == 2'b11) p.burst = 3'b001;
    held = m_hv | (cur.trans[1] & hready);
    e.ready = hready;
    e.resp  = m_dp & resp_ip;
    e.held  = held;
    e.x     = p;
    q.push_back(e);
    @(posedge HCLK);
    if (!HRESETn) begin
      m_hv = 0; m_dp = 0; m_remap = 0; m_h = '0;
    end else begin
      if (readyout_ip) m_dp = active_ip & held & p.sel;
      if (m_hv && m_h.trans == 2'b11 && m_h.burst != 3'b000) m_remap = 1;
      else if (!m_hv && hready && !cur.trans[0]) m_remap = 0;
      if (active_ip && readyout_ip) m_hv = 0;
      else if (cur.sel && cur.trans[1] && hready) begin m_hv = 1; m_h = cur; end
    end
    #1;
  endtask
  task automatic drv(input logic s, input logic [1:0] t, input logic w, input logic [2:0] b,
                     input logic [31:0] a, input logic ac, input logic rd, input logic rs);
    cur = '0;
    cur.sel = s; cur.trans = t; cur.write = w; cur.burst = b; cur.addr = a;
    cur.size = 3'b010; cur.prot = 4'b0011; cur.master = 4'h5;
    active_ip = ac; readyout_ip = rd; resp_ip = rs;
    step();
  endtask
  initial begin
    step();
    step();
    HRESETn = 1'b1;
    step();
    // Granted NONSEQ write, then its data phase
    drv(1, 2'b10, 1, 3'b000, 32'h2000_0010, 1, 1, 0);
    drv(1, 2'b00, 0, 3'b000, 32'h0, 1, 0, 0);
    drv(1, 2'b00, 0, 3'b000, 32'h0, 1, 1, 0);
    // Read held for three ungranted cycles
    for (int i = 0; i < 3; i++) drv(1, 2'b10, 0, 3'b000, 32'h4000_0000, 0, 1, 0);
    drv(1, 2'b10, 0, 3'b000, 32'h4000_0000, 1, 1, 0);
    drv(1, 2'b00, 0, 3'b000, 32'h0, 1, 1, 0);
    // WRAP4 burst with a held SEQ beat
    drv(1, 2'b10, 0, 3'b010, 32'h1000_0000, 1, 1, 0);
    drv(1, 2'b11, 0, 3'b010, 32'h1000_0004, 1, 1, 0);
    drv(1, 2'b11, 0, 3'b010, 32'h1000_0008, 0, 1, 0);
    drv(1, 2'b11, 0, 3'b010, 32'h1000_0008, 1, 1, 0);
    drv(1, 2'b11, 0, 3'b010, 32'h1000_000C, 1, 1, 0);
    drv(1, 2'b10, 0, 3'b010, 32'h1000_0020, 1, 1, 0);
    drv(1, 2'b00, 0, 3'b000, 32'h0, 1, 1, 0);
    // Two-cycle ERROR response
    drv(1, 2'b10, 1, 3'b000, 32'h3000_0000, 1, 1, 0);
    drv(1, 2'b00, 0, 3'b000, 32'h0, 1, 0, 1);
    drv(1, 2'b00, 0, 3'b000, 32'h0, 1, 1, 1);
    // Data phase ends while a new NONSEQ arrives ungranted
    drv(1, 2'b10, 0, 3'b000, 32'h5000_0000, 1, 1, 0);
    drv(1, 2'b10, 0, 3'b000, 32'h5000_0040, 0, 1, 0);
    drv(1, 2'b10, 0, 3'b000, 32'h5000_0040, 1, 1, 0);
    drv(1, 2'b00, 0, 3'b000, 32'h0, 1, 1, 0);
    // Asynchronous reset while a transfer is held
    drv(1, 2'b10, 0, 3'b000, 32'h6000_0000, 0, 1, 0);
    hready = 1'b0;
    #1;
    chk("pre_reset_stall", {63'd0, HREADYOUTS}, 64'd0);
    HRESETn = 1'b0;
    #1;
    chk("reset_hreadyout", {63'd0, HREADYOUTS}, 64'd1);
    chk("reset_held_tran", {63'd0, held_tran_ip}, 64'd0);
    chk("reset_hresp", {63'd0, HRESPS}, 64'd0);
    m_hv = 0; m_dp = 0; m_remap = 0; m_h = '0;
    drv(0, 2'b00, 0, 3'b000, 32'h0, 0, 1, 0);
    HRESETn = 1'b1;
    drv(0, 2'b00, 0, 3'b000, 32'h0, 0, 1, 0);
    // Random traffic; the master holds its address phase while HREADY is low
    for (int i = 0; i < 600; i++) begin
      if (hready) begin
        cur.sel    = ($urandom % 4) != 0;
        cur.trans  = 2'($urandom);
        cur.burst  = 3'($urandom);
        cur.addr   = $urandom;
        cur.write  = 1'($urandom);
        cur.size   = 3'($urandom % 3);
        cur.prot   = 4'($urandom);
        cur.master = 4'($urandom);
        cur.lock   = ($urandom % 8) == 0;
      end
      active_ip   = 1'($urandom);
      readyout_ip = ($urandom % 4) != 0;
      resp_ip     = ($urandom % 8) == 0;
      step();
    end
    @(negedge HCLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ahb_input_stage_dma_phy.md
Name: ahb_input_stage_dma_phy

Overview:
- Per-master input stage of the DMA/PHY AHB bus matrix; sits directly upstream of each output stage.
- Accepts a master's address phase and forwards it live when the target output stage grants this port.
- Holds the address phase in a register and stalls the master when the port is not granted.
- Tracks this port's data phase and returns the slave HREADY/HRESP to the master.

Parameters:
ADDR_WIDTH, 32, address bus width
MASTER_WIDTH, 4, HMASTER width

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  async active-low reset
HSELS  in  1  master-side select
HADDRS  in  ADDR_WIDTH  master address
HTRANSS  in  2  master transfer type
HWRITES  in  1  master direction
HSIZES  in  3  master size
HBURSTS  in  3  master burst
HPROTS  in  4  master protection
HMASTERS  in  MASTER_WIDTH  master ID
HMASTLOCKS  in  1  master lock
HREADYS  in  1  master-side HREADY (fed back from HREADYOUTS mux)
active_ip  in  1  output stage has selected this port
readyout_ip  in  1  HREADYMUX from the output stage
resp_ip  in  1  slave HRESP from the output stage
sel_ip, addr_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip, master_ip, mastlock_ip  out  matching widths  address/control toward the output stage
held_tran_ip  out  1  valid-transfer request to the output stage
HREADYOUTS  out  1  ready to the master
HRESPS  out  1  response to the master

Behaviour:
- Reset: HRESETn (asynchronous, active-low) clears every register: pend_tran=0, data_phase=0, burst_remap=0, capture register all zero.
- Outputs out of reset: HREADYOUTS=1, HRESPS=0; address outputs follow live inputs.
- Capture register loads all address/control inputs on every HCLK edge with HREADYS=1.
- new_tran = HSELS & HTRANSS[1] & HREADYS.
- pend_tran next-state rules, in priority order:
  - active_ip & readyout_ip -> 0 (held transfer accepted by the output stage).
  - new_tran & ~(active_ip & readyout_ip) -> 1.
  - Otherwise hold.
- Address mux, pend_tran=1:
  - All *_ip outputs driven from the capture register.
  - held_tran_ip=1.
- Address mux, pend_tran=0:
  - Outputs driven live from inputs.
  - held_tran_ip = HTRANSS[1] & HREADYS.
- Held SEQ remap:
  - A held transfer whose captured HTRANS=SEQ is presented as trans_ip=NONSEQ(2'b10).
  - If its captured burst is not SINGLE, it is presented as burst_ip=INCR(3'b001) and burst_remap is set.
  - A held NONSEQ is presented unmodified.
- burst_remap:
  - While set, live SEQ transfers use burst_ip=INCR.
  - Cleared on a live NONSEQ or IDLE accepted with HREADYS=1.
- data_phase: when readyout_ip=1, loads active_ip & held_tran_ip & sel_ip; otherwise holds.
- HREADYOUTS:
  - 0 when pend_tran=1.
  - readyout_ip when data_phase=1.
  - 1 otherwise.
- HRESPS = data_phase ? resp_ip : 0. The two-cycle ERROR passes through: first cycle readyout_ip=0, resp=1; second cycle readyout_ip=1, resp=1.
- Latency:
  - Granted transfer: 0 added cycles.
  - Held transfer: 1 stall cycle minimum, plus 1 cycle per cycle without a grant.
- Simultaneous events:
  - Data phase completing while a new transfer arrives ungranted: data_phase clears and pend_tran sets in the same edge.
  - Grant arriving in the same cycle as new_tran: no hold; pend_tran stays 0.
- IDLE or BUSY transfers never set pend_tran; HSELS=0 never sets pend_tran.
- Locked sequences: mastlock_ip passes unchanged from the selected source; the arbiter handles lock.
- Reset mid-hold: the held transfer is discarded and HREADYOUTS returns to 1 asynchronously.

Test Plan:
- Granted NONSEQ write, addr 0x2000_0010, active_ip=1, readyout_ip=1 -> held_tran_ip=1 same cycle, no stall; next cycle data_phase=1 and HREADYOUTS follows readyout_ip.
- NONSEQ read, addr 0x4000_0000, active_ip=0 for 3 cycles then 1 -> HREADYOUTS=0 for 3 cycles; addr_ip=0x4000_0000 held throughout; pend_tran clears on grant.
- Held SEQ from a WRAP4 burst, addr 0x1000_0008 -> trans_ip=2'b10, burst_ip=3'b001; following live SEQ beats also show burst_ip=3'b001 until a NONSEQ arrives.
- Slave returns ERROR (readyout_ip 0 then 1, resp_ip=1 both cycles) -> HRESPS=1 for 2 cycles; HREADYOUTS 0 then 1.
- Data phase ends (readyout_ip=1) while a new NONSEQ arrives with active_ip=0 -> next cycle data_phase=0, pend_tran=1, HREADYOUTS=0.
- HRESETn pulsed low while pend_tran=1 -> HREADYOUTS=1, held_tran_ip=0 immediately; all registers zero.
